output_port_arbiter: RTL

Per-output-port packet arbiter for the minimal NoC router. It shares one output port's 5:1 64-bit flit mux (N, S, E, W, L) among the five input buffers. Each input buffer requests when its head flit routes to this output. The arbiter picks a winner round-robin, drives the mux select code, and holds the grant from head flit to tail flit (wormhole lock). It gates every flit transfer on the downstream ready signal.

---
 rtl/noc_pkg.sv | 20 ++
 rtl/output_port_arbiter_if.sv | 25 ++
 rtl/rr_arbiter_5.sv | 29 ++
 rtl/output_port_arbiter.sv | 69 ++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC router constants: port indices, mux select encoding, arbiter state type.
// Combinational definitions only; no latency.
// No flow control lives here.
package noc_pkg;
    localparam int NUM_PORTS = 5;
    localparam int SEL_W     = 3;

    // Port index doubles as the 5:1 flit mux select code.
    localparam logic [SEL_W-1:0] PORT_N   = 3'd0;
    localparam logic [SEL_W-1:0] PORT_S   = 3'd1;
    localparam logic [SEL_W-1:0] PORT_E   = 3'd2;
    localparam logic [SEL_W-1:0] PORT_W   = 3'd3;
    localparam logic [SEL_W-1:0] PORT_L   = 3'd4;
    localparam logic [SEL_W-1:0] SEL_IDLE = 3'b111;

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } arb_state_e;
endpackage

// File: rtl/output_port_arbiter_if.sv
// Request/grant bundle between the input buffers, the output mux and the port arbiter.
// Wiring only; no latency.
// out_ready from downstream gates every pop.
interface output_port_arbiter_if;
    import noc_pkg::*;

    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] tail;
    logic                 out_ready;
    logic [SEL_W-1:0]     sel;
    logic                 out_valid;
    logic [NUM_PORTS-1:0] grant;
    logic [NUM_PORTS-1:0] pop;
    logic                 busy;

    modport master (
        output req, tail, out_ready,
        input  sel, out_valid, grant, pop, busy
    );

    modport slave (
        input  req, tail, out_ready,
        output sel, out_valid, grant, pop, busy
    );
endinterface

// File: rtl/rr_arbiter_5.sv
// Five-way round-robin pick: search starts one past ptr and wraps modulo 5.
// Purely combinational, zero latency.
// No flow control; the caller decides when to act on the winner.
module rr_arbiter_5
    import noc_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [SEL_W-1:0]     ptr,
    output logic [NUM_PORTS-1:0] winner,
    output logic [SEL_W-1:0]     idx,
    output logic                 any
);
    int cand;

    always_comb begin
        winner = '0;
        idx    = SEL_IDLE;
        any    = 1'b0;
        cand   = 0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = (int'(ptr) + k) % NUM_PORTS;
            if (!any && req[cand]) begin
                any         = 1'b1;
                winner[cand] = 1'b1;
                idx         = SEL_W'(cand);
            end
        end
    end
endmodule

// File: rtl/output_port_arbiter.sv
// Output-port arbiter: round-robin grant held from head to tail flit (wormhole lock).
// Grant takes effect the cycle after req; one bubble cycle between packets.
// Pops only when the owner requests and out_ready is high; flit and sel hold otherwise.
module output_port_arbiter
    import noc_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    output_port_arbiter_if.slave  bus
);
    arb_state_e           state;
    logic [SEL_W-1:0]     owner;
    logic [SEL_W-1:0]     ptr;
    logic [NUM_PORTS-1:0] grant_q;
    logic [NUM_PORTS-1:0] win_onehot;
    logic [SEL_W-1:0]     win_idx;
    logic                 win_any;
    logic                 owner_req;
    logic                 xfer;
    logic                 last;
    logic                 busy;

    rr_arbiter_5 u_rr (
        .req    (bus.req),
        .ptr    (ptr),
        .winner (win_onehot),
        .idx    (win_idx),
        .any    (win_any)
    );

    // grant_q is one-hot of owner while locked and zero when idle, so it masks req/tail directly.
    assign owner_req = |(grant_q & bus.req);
    assign xfer      = owner_req & bus.out_ready;
    assign last      = |(grant_q & bus.tail);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            owner   <= PORT_N;
            ptr     <= PORT_L;
            grant_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_any) begin
                        state   <= ST_LOCKED;
                        owner   <= win_idx;
                        grant_q <= win_onehot;
                    end
                end
                ST_LOCKED: begin
                    // Releasing owner becomes the pointer, giving it lowest priority next round.
                    if (xfer && last) begin
                        state   <= ST_IDLE;
                        ptr     <= owner;
                        grant_q <= '0;
                    end
                end
            endcase
        end
    end

    assign busy          = (state == ST_LOCKED);
    assign bus.busy      = busy;
    assign bus.grant     = grant_q;
    assign bus.sel       = busy ? owner : SEL_IDLE;
    assign bus.out_valid = owner_req;
    assign bus.pop       = grant_q & bus.req & {NUM_PORTS{bus.out_ready}};
endmodule
